// File: rtl/rs_encode_pkg.sv
// rs_encode_pkg
// Shared definitions for the RS encode stream controllers: the output
// controller state encoding, default counter widths and a width helper.
// No ports (package).
package rs_encode_pkg;

    // Counter width for a modulus of n; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned RS_BLOCK_LINES  = 8;
    localparam int unsigned RS_BLOCK_CNT_W  = 16;
    localparam int unsigned RS_LINE_CNT_W   = cnt_w(RS_BLOCK_LINES);

    // Encoding 2'b11 is illegal and is trapped by the FSM default branch.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        META_OUT  = 2'd1,
        BLOCK_OUT = 2'd2
    } rs_out_state_t;

endpackage

// File: rtl/rs_unit_out_mux.sv
// rs_unit_out_mux
// Selects one RS encode unit's line stream and steers the downstream ready
// back to that unit only.
// Ports:
//   unit_sel      - index of the unit currently being drained
//   dst_rdy       - downstream line ready
//   unit_val      - per-unit line valid
//   unit_data     - per-unit lines, unit i at [i*DATA_W +: DATA_W]
//   unit_rdy      - one-hot (or zero) per-unit ready
//   sel_val       - valid of the selected unit
//   sel_data      - line of the selected unit
import rs_encode_pkg::*;

module rs_unit_out_mux #(
    parameter int unsigned NUM_RS_UNITS = 4,
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned SEL_W        = cnt_w(NUM_RS_UNITS)
) (
    input  logic [SEL_W-1:0]               unit_sel,
    input  logic                           dst_rdy,
    input  logic [NUM_RS_UNITS-1:0]        unit_val,
    input  logic [NUM_RS_UNITS*DATA_W-1:0] unit_data,
    output logic [NUM_RS_UNITS-1:0]        unit_rdy,
    output logic                           sel_val,
    output logic [DATA_W-1:0]              sel_data
);

    // Compare-based select keeps out-of-range unit_sel values harmless when
    // NUM_RS_UNITS is not a power of two.
    always_comb begin
        unit_rdy = '0;
        sel_val  = 1'b0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_RS_UNITS; i++) begin
            if (unit_sel == SEL_W'(i)) begin
                unit_rdy[i] = dst_rdy;
                sel_val     = unit_val[i];
                sel_data    = unit_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/rs_encode_stream_out_ctrl.sv
// rs_encode_stream_out_ctrl
// Output controller of the RS encode stream: accepts a request (block count),
// emits one header, then drains BLOCK_LINES lines per block from the RS
// units in round-robin order starting at unit 0, flagging the final line.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   in_ctrl_out_ctrl_*             - request metadata (val/rdy, num_blocks)
//   out_ctrl_dst_meta_val/_rdy     - output header handshake
//   out_ctrl_dst_num_blocks        - latched block count for the header
//   rs_unit_out_ctrl_val/_data     - per-unit line streams
//   out_ctrl_rs_unit_rdy           - per-unit ready, only the selected unit
//   out_ctrl_dst_data_*            - output line stream with last marker
import rs_encode_pkg::*;

module rs_encode_stream_out_ctrl #(
    parameter int unsigned NUM_RS_UNITS = 4,
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned BLOCK_LINES  = RS_BLOCK_LINES,
    parameter int unsigned BLOCK_CNT_W  = RS_BLOCK_CNT_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_ctrl_out_ctrl_val,
    output logic                           out_ctrl_in_ctrl_rdy,
    input  logic [BLOCK_CNT_W-1:0]         in_ctrl_out_ctrl_num_blocks,
    output logic                           out_ctrl_dst_meta_val,
    input  logic                           dst_out_ctrl_meta_rdy,
    output logic [BLOCK_CNT_W-1:0]         out_ctrl_dst_num_blocks,
    input  logic [NUM_RS_UNITS-1:0]        rs_unit_out_ctrl_val,
    output logic [NUM_RS_UNITS-1:0]        out_ctrl_rs_unit_rdy,
    input  logic [NUM_RS_UNITS*DATA_W-1:0] rs_unit_out_ctrl_data,
    output logic                           out_ctrl_dst_data_val,
    input  logic                           dst_out_ctrl_data_rdy,
    output logic [DATA_W-1:0]              out_ctrl_dst_data,
    output logic                           out_ctrl_dst_data_last
);

    localparam int unsigned LINE_CNT_W = cnt_w(BLOCK_LINES);
    localparam int unsigned SEL_W      = cnt_w(NUM_RS_UNITS);
    localparam logic [LINE_CNT_W-1:0] LINE_MAX = LINE_CNT_W'(BLOCK_LINES - 1);
    localparam logic [SEL_W-1:0]      SEL_MAX  = SEL_W'(NUM_RS_UNITS - 1);

    rs_out_state_t           state;
    logic [LINE_CNT_W-1:0]   line_cnt;
    logic [BLOCK_CNT_W-1:0]  block_cnt;
    logic [BLOCK_CNT_W-1:0]  num_blocks;
    logic [BLOCK_CNT_W-1:0]  last_block;
    logic [SEL_W-1:0]        unit_sel;
    logic                    in_rdy_q;
    logic                    meta_val_q;

    logic [NUM_RS_UNITS-1:0] mux_rdy;
    logic                    mux_val;
    logic [DATA_W-1:0]       mux_data;
    logic                    line_end;
    logic                    xfer;

    rs_unit_out_mux #(
        .NUM_RS_UNITS (NUM_RS_UNITS),
        .DATA_W       (DATA_W),
        .SEL_W        (SEL_W)
    ) u_mux (
        .unit_sel  (unit_sel),
        .dst_rdy   (dst_out_ctrl_data_rdy),
        .unit_val  (rs_unit_out_ctrl_val),
        .unit_data (rs_unit_out_ctrl_data),
        .unit_rdy  (mux_rdy),
        .sel_val   (mux_val),
        .sel_data  (mux_data)
    );

    assign out_ctrl_in_ctrl_rdy    = in_rdy_q;
    assign out_ctrl_dst_meta_val   = meta_val_q;
    assign out_ctrl_dst_num_blocks = num_blocks;

    assign last_block = num_blocks - BLOCK_CNT_W'(1);
    assign line_end   = (line_cnt == LINE_MAX);
    assign xfer       = out_ctrl_dst_data_val & dst_out_ctrl_data_rdy;

    // Line path is a zero-latency pass-through, gated to BLOCK_OUT only.
    always_comb begin
        out_ctrl_dst_data_val  = 1'b0;
        out_ctrl_rs_unit_rdy   = '0;
        out_ctrl_dst_data      = '0;
        out_ctrl_dst_data_last = 1'b0;
        case (state)
            IDLE, META_OUT: begin
            end
            BLOCK_OUT: begin
                out_ctrl_dst_data_val  = mux_val;
                out_ctrl_rs_unit_rdy   = mux_rdy;
                out_ctrl_dst_data      = mux_data;
                out_ctrl_dst_data_last = line_end && (block_cnt == last_block);
            end
            default: begin
                out_ctrl_dst_data_val  = 1'bx;
                out_ctrl_rs_unit_rdy   = 'x;
                out_ctrl_dst_data      = 'x;
                out_ctrl_dst_data_last = 1'bx;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            line_cnt   <= '0;
            block_cnt  <= '0;
            unit_sel   <= '0;
            num_blocks <= '0;
            in_rdy_q   <= 1'b1;
            meta_val_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ctrl_out_ctrl_val) begin
                        num_blocks <= in_ctrl_out_ctrl_num_blocks;
                        line_cnt   <= '0;
                        block_cnt  <= '0;
                        unit_sel   <= '0;
                        in_rdy_q   <= 1'b0;
                        meta_val_q <= 1'b1;
                        state      <= META_OUT;
                    end
                end
                META_OUT: begin
                    if (dst_out_ctrl_meta_rdy) begin
                        meta_val_q <= 1'b0;
                        if (num_blocks == '0) begin
                            in_rdy_q <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            state <= BLOCK_OUT;
                        end
                    end
                end
                BLOCK_OUT: begin
                    if (xfer) begin
                        if (line_end) begin
                            line_cnt  <= '0;
                            block_cnt <= block_cnt + BLOCK_CNT_W'(1);
                            unit_sel  <= (unit_sel == SEL_MAX) ? '0 : unit_sel + SEL_W'(1);
                            if (out_ctrl_dst_data_last) begin
                                in_rdy_q <= 1'b1;
                                state    <= IDLE;
                            end
                        end else begin
                            line_cnt <= line_cnt + LINE_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state      <= rs_out_state_t'('x);
                    line_cnt   <= 'x;
                    block_cnt  <= 'x;
                    unit_sel   <= 'x;
                    num_blocks <= 'x;
                    in_rdy_q   <= 1'bx;
                    meta_val_q <= 1'bx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_encode_stream_out_ctrl.sv
// tb_rs_encode_stream_out_ctrl
// Self-checking bench: RS units are modelled as counters producing tagged
// lines; expected lines/headers are queued when a request is issued and
// popped as the DUT hands them downstream.
module tb_rs_encode_stream_out_ctrl;

    localparam int NU  = 4;
    localparam int DW  = 256;
    localparam int BL  = 8;
    localparam int BCW = 16;
    localparam int LIMIT = 2000;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          last;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              in_val;
    logic              in_rdy;
    logic [BCW-1:0]    in_nb;
    logic              meta_val;
    logic              meta_rdy;
    logic [BCW-1:0]    dst_nb;
    logic [NU-1:0]     unit_val;
    logic [NU-1:0]     unit_rdy;
    logic [NU*DW-1:0]  unit_data;
    logic              data_val;
    logic              data_rdy;
    logic [DW-1:0]     data;
    logic              last;

    rs_encode_stream_out_ctrl #(
        .NUM_RS_UNITS (NU),
        .DATA_W       (DW),
        .BLOCK_LINES  (BL),
        .BLOCK_CNT_W  (BCW)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .in_ctrl_out_ctrl_val        (in_val),
        .out_ctrl_in_ctrl_rdy        (in_rdy),
        .in_ctrl_out_ctrl_num_blocks (in_nb),
        .out_ctrl_dst_meta_val       (meta_val),
        .dst_out_ctrl_meta_rdy       (meta_rdy),
        .out_ctrl_dst_num_blocks     (dst_nb),
        .rs_unit_out_ctrl_val        (unit_val),
        .out_ctrl_rs_unit_rdy        (unit_rdy),
        .rs_unit_out_ctrl_data       (unit_data),
        .out_ctrl_dst_data_val       (data_val),
        .dst_out_ctrl_data_rdy       (data_rdy),
        .out_ctrl_dst_data           (data),
        .out_ctrl_dst_data_last      (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks;
    int   errors;
    int   lines_seen;
    int   meta_cnt;
    int   unit_cnt  [NU];
    int   model_cnt [NU];
    exp_t exp_q [$];
    int   nb_q  [$];
    bit   rand_mode;
    bit   any_unit_rdy;

    logic          s_in_rdy;
    logic          s_meta_val;
    logic          s_data_val;
    logic [NU-1:0] s_unit_rdy;
    logic          s_last;

    function automatic logic [DW-1:0] mk(input int u, input int k);
        logic [DW-1:0] r;
        r = {8{k[15:0], 8'hA5, u[7:0]}};
        return r;
    endfunction

    task automatic drive_units();
        for (int i = 0; i < NU; i++) begin
            unit_val[i] = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            unit_data[i*DW +: DW] = mk(i, unit_cnt[i]);
        end
        data_rdy = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        meta_rdy = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // One clock: sample and score at negedge, update stimulus after posedge.
    task automatic tick();
        logic [NU-1:0] hs;
        exp_t e;
        int   enb;
        @(negedge clk);
        s_in_rdy   = in_rdy;
        s_meta_val = meta_val;
        s_data_val = data_val;
        s_unit_rdy = unit_rdy;
        s_last     = last;
        hs = '0;
        if (!rst) begin
            hs = unit_val & unit_rdy;
            if (|unit_rdy) any_unit_rdy = 1'b1;
            if (meta_val && meta_rdy) begin
                meta_cnt++;
                checks++;
                if (nb_q.size() == 0) begin
                    errors++;
                    $display("FAIL meta_unexpected: header with num_blocks=%0d, none expected", dst_nb);
                end else begin
                    enb = nb_q.pop_front();
                    if (dst_nb !== BCW'(enb)) begin
                        errors++;
                        $display("FAIL meta_num_blocks: got %0d expected %0d", dst_nb, enb);
                    end
                end
            end
            if (data_val && data_rdy) begin
                lines_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL line_unexpected: got data=%h last=%b, none expected", data, last);
                end else begin
                    e = exp_q.pop_front();
                    if (data !== e.d || last !== e.last) begin
                        errors++;
                        $display("FAIL line_%0d: got data=%h last=%b expected data=%h last=%b",
                                 lines_seen, data, last, e.d, e.last);
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NU; i++)
            if (hs[i]) unit_cnt[i]++;
        drive_units();
    endtask

    task automatic push_req(input int nb);
        exp_t e;
        int   u;
        nb_q.push_back(nb);
        for (int b = 0; b < nb; b++) begin
            u = b % NU;
            for (int l = 0; l < BL; l++) begin
                e.d    = mk(u, model_cnt[u]);
                e.last = (b == nb - 1) && (l == BL - 1);
                model_cnt[u]++;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic resync();
        for (int i = 0; i < NU; i++) model_cnt[i] = unit_cnt[i];
    endtask

    task automatic wait_accept();
        int c;
        for (c = 0; c < LIMIT; c++) begin
            tick();
            if (s_in_rdy && in_val) break;
        end
        checks++;
        if (c == LIMIT) begin
            errors++;
            $display("FAIL accept_timeout: in_rdy=%b after %0d cycles, expected 1", s_in_rdy, LIMIT);
        end
    endtask

    task automatic wait_idle();
        int c;
        for (c = 0; c < LIMIT; c++) begin
            tick();
            if (s_in_rdy) break;
        end
        checks++;
        if (c == LIMIT) begin
            errors++;
            $display("FAIL idle_timeout: in_rdy=%b after %0d cycles, expected 1", s_in_rdy, LIMIT);
        end
    endtask

    task automatic do_request(input int nb, input string name);
        int m0, l0;
        resync();
        push_req(nb);
        m0 = meta_cnt;
        l0 = lines_seen;
        in_nb  = BCW'(nb);
        in_val = 1'b1;
        wait_accept();
        in_val = 1'b0;
        wait_idle();
        checks++;
        if (meta_cnt - m0 != 1) begin
            errors++;
            $display("FAIL %s_headers: got %0d expected 1", name, meta_cnt - m0);
        end
        checks++;
        if (lines_seen - l0 != nb * BL) begin
            errors++;
            $display("FAIL %s_line_count: got %0d expected %0d", name, lines_seen - l0, nb * BL);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d lines outstanding expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks += 5;
        if (s_in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b expected 1", s_in_rdy); end
        if (s_meta_val !== 1'b0) begin errors++; $display("FAIL reset_meta_val: got %b expected 0", s_meta_val); end
        if (s_data_val !== 1'b0) begin errors++; $display("FAIL reset_data_val: got %b expected 0", s_data_val); end
        if (s_unit_rdy !== '0) begin errors++; $display("FAIL reset_unit_rdy: got %b expected 0000", s_unit_rdy); end
        if (s_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", s_last); end
    endtask

    task automatic test_three_blocks();
        do_request(3, "three");
    endtask

    task automatic test_six_blocks();
        do_request(6, "six");
    endtask

    task automatic test_zero_blocks();
        any_unit_rdy = 1'b0;
        do_request(0, "zero");
        checks++;
        if (any_unit_rdy) begin
            errors++;
            $display("FAIL zero_unit_rdy: got a unit rdy pulse expected none");
        end
    endtask

    task automatic test_random_stalls();
        rand_mode = 1'b1;
        do_request(5, "random");
        rand_mode = 1'b0;
    endtask

    task automatic test_back_to_back();
        int l0;
        resync();
        push_req(2);
        push_req(1);
        l0 = lines_seen;
        in_nb  = BCW'(2);
        in_val = 1'b1;
        wait_accept();
        in_nb = BCW'(1);
        wait_idle();
        checks++;
        if (lines_seen - l0 != 2 * BL) begin
            errors++;
            $display("FAIL overlap_in_rdy: rose after %0d lines expected after %0d", lines_seen - l0, 2 * BL);
        end
        in_val = 1'b0;
        wait_idle();
        checks++;
        if (lines_seen - l0 != 3 * BL || exp_q.size() != 0 || nb_q.size() != 0) begin
            errors++;
            $display("FAIL overlap_total: got %0d lines (%0d pending) expected %0d",
                     lines_seen - l0, exp_q.size(), 3 * BL);
        end
    endtask

    task automatic test_reset_mid_block();
        int l0, c;
        resync();
        push_req(3);
        l0 = lines_seen;
        in_nb  = BCW'(3);
        in_val = 1'b1;
        wait_accept();
        in_val = 1'b0;
        for (c = 0; c < LIMIT; c++) begin
            tick();
            if (lines_seen - l0 >= BL + 3) break;
        end
        checks++;
        if (c == LIMIT) begin
            errors++;
            $display("FAIL midrst_progress: got %0d lines expected %0d", lines_seen - l0, BL + 3);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks += 4;
        if (s_in_rdy !== 1'b1) begin errors++; $display("FAIL midrst_in_rdy: got %b expected 1", s_in_rdy); end
        if (s_data_val !== 1'b0) begin errors++; $display("FAIL midrst_data_val: got %b expected 0", s_data_val); end
        if (s_unit_rdy !== '0) begin errors++; $display("FAIL midrst_unit_rdy: got %b expected 0000", s_unit_rdy); end
        if (s_meta_val !== 1'b0) begin errors++; $display("FAIL midrst_meta_val: got %b expected 0", s_meta_val); end
        exp_q.delete();
        nb_q.delete();
        do_request(2, "after_rst");
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        lines_seen = 0;
        meta_cnt   = 0;
        rand_mode  = 1'b0;
        any_unit_rdy = 1'b0;
        for (int i = 0; i < NU; i++) begin
            unit_cnt[i]  = 0;
            model_cnt[i] = 0;
        end
        rst    = 1'b1;
        in_val = 1'b0;
        in_nb  = '0;
        drive_units();

        test_reset();
        test_three_blocks();
        test_six_blocks();
        test_zero_blocks();
        test_random_stalls();
        test_back_to_back();
        test_reset_mid_block();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_encode_stream_out_ctrl.md
RS_ENCODE_STREAM_OUT_CTRL -- requirements
Module: rs_encode_stream_out_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- NUM_RS_UNITS, 4, number of RS encode units, served round-robin.
- DATA_W, 256, line width in bits.
- BLOCK_LINES, 8, output lines per encoded block (data plus parity).
- BLOCK_CNT_W, 16, block-count width.
REQ-002 Ports, one per line (name, direction, width, meaning); clock and reset first:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- in_ctrl_out_ctrl_val, in, 1, request metadata valid.
- out_ctrl_in_ctrl_rdy, out, 1, request metadata ready.
- in_ctrl_out_ctrl_num_blocks, in, BLOCK_CNT_W, number of blocks in the request.
- out_ctrl_dst_meta_val, out, 1, output header valid.
- dst_out_ctrl_meta_rdy, in, 1, output header ready.
- out_ctrl_dst_num_blocks, out, BLOCK_CNT_W, latched block count.
- rs_unit_out_ctrl_val, in, NUM_RS_UNITS, per-unit line valid.
- out_ctrl_rs_unit_rdy, out, NUM_RS_UNITS, per-unit line ready.
- rs_unit_out_ctrl_data, in, NUM_RS_UNITS*DATA_W, per-unit lines; unit i occupies bits [i*DATA_W +: DATA_W].
- out_ctrl_dst_data_val, out, 1, output line valid.
- dst_out_ctrl_data_rdy, in, 1, output line ready.
- out_ctrl_dst_data, out, DATA_W, output line.
- out_ctrl_dst_data_last, out, 1, marks the final line of the request.

Function
REQ-003 The FSM SHALL have three states: IDLE, META_OUT and BLOCK_OUT.
REQ-004 IDLE behaviour:
- out_ctrl_in_ctrl_rdy=1.
- On val: latch num_blocks, clear line_cnt, block_cnt and unit_sel, then go to META_OUT.
REQ-005 META_OUT behaviour:
- out_ctrl_dst_meta_val=1.
- On dst_out_ctrl_meta_rdy: go to IDLE if the latched num_blocks==0, otherwise go to BLOCK_OUT.
REQ-006 BLOCK_OUT SHALL pass the selected unit through combinationally with zero latency:
- out_ctrl_dst_data_val = rs_unit_out_ctrl_val[unit_sel].
- out_ctrl_dst_data = slice unit_sel of rs_unit_out_ctrl_data.
- out_ctrl_rs_unit_rdy[unit_sel] = dst_out_ctrl_data_rdy; all other rdy bits = 0.
REQ-007 A line transfer is unit val AND dst rdy; each transfer SHALL increment line_cnt.
REQ-008 On a transfer with line_cnt==BLOCK_LINES-1, the block SHALL end:
- line_cnt returns to 0 and block_cnt increments.
- unit_sel increments, wrapping from NUM_RS_UNITS-1 to 0.
REQ-009 out_ctrl_dst_data_last SHALL be 1 only when line_cnt==BLOCK_LINES-1 and block_cnt==num_blocks-1; on the transfer of that line the FSM SHALL go to IDLE.
REQ-010 With no transfer, all counters and the state SHALL hold; val/rdy stalls on either side SHALL NOT drop or duplicate lines.
REQ-011 Outside BLOCK_OUT:
- all out_ctrl_rs_unit_rdy bits = 0;
- out_ctrl_dst_data_val = 0;
- out_ctrl_dst_data_last = 0.
REQ-012 out_ctrl_in_ctrl_rdy SHALL be 0 outside IDLE, so a new request never overlaps the current one.
REQ-013 Counter widths SHALL be $clog2(BLOCK_LINES) for line_cnt and BLOCK_CNT_W for block_cnt; unit_sel SHALL be $clog2(NUM_RS_UNITS) bits, with an explicit compare-and-wrap when NUM_RS_UNITS is not a power of two.
REQ-014 Valid outputs SHALL NOT depend combinationally on their own rdy inputs.

Reset
REQ-015 While rst=1, the state SHALL be IDLE and line_cnt, block_cnt, unit_sel and num_blocks SHALL be 0.
REQ-016 In the first cycle after rst is deasserted:
- out_ctrl_in_ctrl_rdy=1;
- all other valid and rdy outputs = 0.
REQ-017 Reset asserted mid-block SHALL abandon the request; no partial state persists.
REQ-018 Undefined state encodings SHALL drive X on outputs and next-state, to expose illegal states in simulation.

Structure
REQ-019 The state enum and the line/block counter width localparams SHALL live in package rs_encode_pkg, shared with the input controller.
REQ-020 Sub-module rs_unit_out_mux SHALL implement the one-hot ready decode and the data/valid select from unit_sel; the FSM and counters SHALL stay in the top module.

Verification
REQ-021 Directed scenarios the bench SHALL cover:
- num_blocks=3, NUM_RS_UNITS=4, BLOCK_LINES=8, all rdy/val high -> header, then 24 lines from units 0,1,2 in order; last on line 24; back to IDLE.
- num_blocks=6, NUM_RS_UNITS=4 -> block order 0,1,2,3,0,1; last asserted only on line 48.
- num_blocks=0 -> one header, no data lines, return to IDLE with no rdy bit to any unit.
- Random dst_out_ctrl_data_rdy at 50% and unit val gaps, 5 blocks -> exact 40-line sequence, no loss or duplication.
- New in_ctrl val asserted during BLOCK_OUT -> out_ctrl_in_ctrl_rdy stays 0 until after the last line.
- rst pulsed after line 3 of block 1 -> IDLE next cycle, counters 0, new request starts at unit 0.
